axi_st_patgen_seq: RTL and testbench
====================================

AXI_ST_PATGEN_SEQ -- requirements
Module: axi_st_patgen_seq

Interface
REQ-001 The parameter shall be TIMEOUT_W, default 16, giving the width of the per-pattern watchdog.
REQ-002 The ports shall be, clock and reset first:
- wr_clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to run a test sequence.
- cfg_pat_mask  in  3  pattern enables: bit0 fixed, bit1 random, bit2 incrementing.
- cfg_beats  in  9  beats per pattern.
- cfg_timeout  in  TIMEOUT_W  per-pattern watchdog limit, in cycles.
- patgen_en  out  1  pattern generator enable pulse.
- patgen_sel  out  2  pattern select: 00 fixed, 01 random, 10 incrementing.
- patgen_cnt  out  9  beat count passed to the generator.
- axist_valid  in  1  observed stream valid.
- axist_rdy  in  1  observed stream ready.
- chk_done  in  1  checker completion pulse.
- chk_pass  in  1  checker result, qualified by chk_done.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  single-cycle end-of-sequence pulse.
- pass_vec  out  3  per-pattern pass flags, same bit order as cfg_pat_mask.
- timeout_err  out  1  sticky watchdog-expiry flag.
- beat_cnt  out  9  accepted beats in the current pattern.

Function
REQ-003 The state machine shall have exactly these states: IDLE, LOAD, RUN, CHECK, DONE.
REQ-004 In IDLE, a start pulse shall latch cfg_pat_mask, cfg_beats and cfg_timeout, and clear pass_vec and timeout_err.
- Mask nonzero: go to LOAD with the pattern index set to the lowest set mask bit.
- Mask zero: go to DONE.
REQ-005 A start pulse seen in any state other than IDLE shall be ignored, and the latched configuration shall not change.
REQ-006 LOAD shall last exactly 1 cycle and then go to RUN.
- patgen_en = 1 for that one cycle only.
- patgen_sel = code of the current index; patgen_cnt = latched beats.
- beat_cnt and the watchdog shall both clear to 0.
REQ-007 patgen_sel and patgen_cnt shall hold their values from LOAD until the next LOAD.
REQ-008 In RUN, beat_cnt shall increment on each cycle with axist_valid & axist_rdy.
- Enter CHECK on the cycle in which the accepted beat makes beat_cnt equal latched beats.
- Latched beats = 0: leave RUN for CHECK after one cycle with no beats required.
REQ-009 Handshakes seen outside RUN shall not change beat_cnt, and beat_cnt shall saturate at 511.
REQ-010 The watchdog shall increment every cycle in RUN and CHECK.
- When it equals cfg_timeout: set timeout_err, clear pass_vec[index], advance per REQ-012.
- cfg_timeout = 0 disables the watchdog.
REQ-011 In CHECK, chk_done shall write chk_pass into pass_vec[index] and advance per REQ-012.
- chk_done outside CHECK shall be ignored.
- chk_done and watchdog expiry in the same cycle: chk_done wins and timeout_err is not set.
REQ-012 Advance shall go to LOAD for the next-higher set mask bit, or to DONE if no set bit remains.
REQ-013 DONE shall last 1 cycle with done = 1 and then return to IDLE.
- pass_vec and timeout_err hold until the next accepted start.
REQ-014 Mask bits that are clear shall leave their pass_vec bits at 0.

Reset
REQ-015 Asserting rst shall, asynchronously at any point including mid-sequence, force:
- state IDLE;
- all outputs 0 (patgen_sel 00, patgen_cnt 0, beat_cnt 0, pass_vec 000);
- the watchdog and all latched configuration to 0.
REQ-016 The first start after rst deasserts shall be honoured on the first clock edge.

Structure
REQ-017 Package axi_st_seq_pkg shall hold:
- the state encoding;
- the patgen_sel codes (SEL_FIXED, SEL_RAND, SEL_INCR);
- the mask bit positions.
REQ-018 The watchdog shall be the sub-module axi_st_seq_timer, with clear, enable, limit and expire, and parameter TIMEOUT_W.
REQ-019 The block shall contain no FIFOs or datapath; it only sequences the generator and checker.

Verification
REQ-020 The bench shall cover at least these directed scenarios:
- mask=111, beats=4, ready always high, chk_pass=1 each time -> three LOAD pulses with sel 00,01,10; done after the third CHECK; pass_vec=111; timeout_err=0.
- mask=101, beats=3, chk_pass=0 for the incrementing pattern -> sel 00 then 10, random pattern skipped; pass_vec=001.
- mask=010, beats=8, timeout=20, axist_rdy held low -> watchdog expires 20 cycles after LOAD; timeout_err=1; pass_vec=000; done pulse.
- mask=001, beats=2, chk_done coincident with watchdog expiry -> chk_pass is taken; timeout_err=0.
- rst asserted in RUN with beat_cnt=3 -> all outputs 0 and state IDLE immediately; a later start runs normally.
- start pulsed again during RUN -> no effect; mask=000 start from IDLE -> done pulse on the next cycle, pass_vec=000.

Source files
------------

// File: rtl/axi_st_seq_pkg.sv
// Shared definitions for the AXI-stream pattern test sequencer: state
// encoding, pattern select codes, mask bit positions and index helpers.
package axi_st_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // Pattern select codes presented on patgen_sel
    localparam logic [1:0] SEL_FIXED = 2'b00;
    localparam logic [1:0] SEL_RAND  = 2'b01;
    localparam logic [1:0] SEL_INCR  = 2'b10;

    // Bit positions inside cfg_pat_mask / pass_vec
    localparam int MASK_FIXED = 0;
    localparam int MASK_RAND  = 1;
    localparam int MASK_INCR  = 2;
    localparam int NUM_PAT    = 3;

    localparam logic [8:0] BEAT_MAX = 9'd511;

    // Map a pattern index (mask bit position) to its generator select code
    function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
        logic [1:0] sel;
        case (idx)
            2'd1:    sel = SEL_RAND;
            2'd2:    sel = SEL_INCR;
            default: sel = SEL_FIXED;
        endcase
        return sel;
    endfunction

    // Lowest set mask bit at or above position lo; result is {found, index}
    function automatic logic [2:0] find_set(input logic [2:0] mask, input logic [2:0] lo);
        logic [2:0] r;
        r = 3'b000;
        for (int i = NUM_PAT - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(lo))) begin
                r = {1'b1, i[1:0]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_st_seq_timer.sv
// Per-pattern watchdog. Counts enabled cycles since the last clear and
// flags expiry in the cycle whose count reaches the limit. A zero limit
// disables expiry entirely.
module axi_st_seq_timer #(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic                 expire
);

    logic [TIMEOUT_W-1:0] count_reg;

    // Cycle counter: clear has priority over counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + TIMEOUT_W'(1);
        end
    end

    // Extra bit on the compare keeps a limit of all-ones reachable
    assign expire = enable && !clear && (limit != '0) &&
                    (({1'b0, count_reg} + (TIMEOUT_W + 1)'(1)) == {1'b0, limit});

endmodule

// File: rtl/axi_st_patgen_seq.sv
// Test sequencer: walks the enabled patterns in mask order, pulses the
// generator for each one, counts accepted stream beats, collects the
// checker verdict and guards every pattern with a watchdog.
module axi_st_patgen_seq #(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 wr_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           cfg_pat_mask,
    input  logic [8:0]           cfg_beats,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    output logic                 patgen_en,
    output logic [1:0]           patgen_sel,
    output logic [8:0]           patgen_cnt,
    input  logic                 axist_valid,
    input  logic                 axist_rdy,
    input  logic                 chk_done,
    input  logic                 chk_pass,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           pass_vec,
    output logic                 timeout_err,
    output logic [8:0]           beat_cnt
);

    import axi_st_seq_pkg::*;

    seq_state_t           state_reg, state_next;
    logic [1:0]           idx_reg, idx_next;
    logic [2:0]           mask_reg;
    logic [8:0]           beats_reg;
    logic [TIMEOUT_W-1:0] timeout_reg;
    logic [1:0]           sel_reg;
    logic [8:0]           cnt_reg;
    logic [8:0]           beat_cnt_reg;
    logic [2:0]           pass_reg, pass_next;
    logic                 terr_reg;

    logic       load_cfg, wd_clear, wd_enable, wd_expire;
    logic       beat_clear, beat_inc, pass_wr, pass_val, terr_set, advance;
    logic       handshake;
    logic [2:0] start_find, adv_find;

    assign handshake  = axist_valid & axist_rdy;
    assign start_find = find_set(cfg_pat_mask, 3'd0);
    assign adv_find   = find_set(mask_reg, {1'b0, idx_reg} + 3'd1);

    axi_st_seq_timer #(
        .TIMEOUT_W(TIMEOUT_W)
    ) u_timer (
        .clk    (wr_clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .limit  (timeout_reg),
        .expire (wd_expire)
    );

    // Next-state and control decode; a finished pattern hops to the next enabled one
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        load_cfg   = 1'b0;
        wd_clear   = 1'b0;
        wd_enable  = 1'b0;
        beat_clear = 1'b0;
        beat_inc   = 1'b0;
        pass_wr    = 1'b0;
        pass_val   = 1'b0;
        terr_set   = 1'b0;
        advance    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    load_cfg = 1'b1;
                    if (start_find[2]) begin
                        state_next = ST_LOAD;
                        idx_next   = start_find[1:0];
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                wd_clear   = 1'b1;
                beat_clear = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                wd_enable = 1'b1;
                if (handshake && (beat_cnt_reg != BEAT_MAX)) begin
                    beat_inc = 1'b1;
                end
                if (wd_expire) begin
                    terr_set = 1'b1;
                    pass_wr  = 1'b1;
                    advance  = 1'b1;
                end else if (beats_reg == 9'd0) begin
                    state_next = ST_CHECK;
                end else if (handshake && ((beat_cnt_reg + 9'd1) == beats_reg)) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                wd_enable = 1'b1;
                // The checker verdict beats a watchdog expiry in the same cycle
                if (chk_done) begin
                    pass_wr  = 1'b1;
                    pass_val = chk_pass;
                    advance  = 1'b1;
                end else if (wd_expire) begin
                    terr_set = 1'b1;
                    pass_wr  = 1'b1;
                    advance  = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (advance) begin
            if (adv_find[2]) begin
                state_next = ST_LOAD;
                idx_next   = adv_find[1:0];
            end else begin
                state_next = ST_DONE;
            end
        end
    end

    // State and current pattern index
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Configuration captured only by a start accepted in IDLE
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            mask_reg    <= 3'b000;
            beats_reg   <= 9'd0;
            timeout_reg <= '0;
        end else if (load_cfg) begin
            mask_reg    <= cfg_pat_mask;
            beats_reg   <= cfg_beats;
            timeout_reg <= cfg_timeout;
        end
    end

    // Generator select/count are set on entry to LOAD and held until the next LOAD
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            sel_reg <= SEL_FIXED;
            cnt_reg <= 9'd0;
        end else if (state_next == ST_LOAD) begin
            sel_reg <= idx_to_sel(idx_next);
            cnt_reg <= load_cfg ? cfg_beats : beats_reg;
        end
    end

    // Accepted-beat counter, cleared in LOAD, counting only in RUN
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            beat_cnt_reg <= 9'd0;
        end else if (beat_clear) begin
            beat_cnt_reg <= 9'd0;
        end else if (beat_inc) begin
            beat_cnt_reg <= beat_cnt_reg + 9'd1;
        end
    end

    // Per-pattern result bits: cleared by a new run, written for the current index only
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PAT; gi++) begin : g_pass
            assign pass_next[gi] = load_cfg ? 1'b0 :
                                   (pass_wr && (idx_reg == 2'(gi))) ? pass_val :
                                   pass_reg[gi];
        end
    endgenerate

    // Result flags: pass bits and sticky watchdog error
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            pass_reg <= 3'b000;
            terr_reg <= 1'b0;
        end else begin
            pass_reg <= pass_next;
            if (load_cfg) begin
                terr_reg <= 1'b0;
            end else if (terr_set) begin
                terr_reg <= 1'b1;
            end
        end
    end

    assign patgen_en   = (state_reg == ST_LOAD);
    assign busy        = (state_reg != ST_IDLE);
    assign done        = (state_reg == ST_DONE);
    assign patgen_sel  = sel_reg;
    assign patgen_cnt  = cnt_reg;
    assign beat_cnt    = beat_cnt_reg;
    assign pass_vec    = pass_reg;
    assign timeout_err = terr_reg;

endmodule

// File: tb/tb_axi_st_patgen_seq.sv
// Bench for the pattern test sequencer: directed table rows, a mid-run
// reset sequence and randomized runs, all checked against a
// per-pattern timing model derived from the sequencing rules.
module tb_axi_st_patgen_seq;

    localparam int TW = 16;

    logic          wr_clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    cfg_pat_mask = 3'b000;
    logic [8:0]    cfg_beats = 9'd0;
    logic [TW-1:0] cfg_timeout = '0;
    logic          patgen_en;
    logic [1:0]    patgen_sel;
    logic [8:0]    patgen_cnt;
    logic          axist_valid = 1'b0;
    logic          axist_rdy = 1'b0;
    logic          chk_done = 1'b0;
    logic          chk_pass = 1'b0;
    logic          busy;
    logic          done;
    logic [2:0]    pass_vec;
    logic          timeout_err;
    logic [8:0]    beat_cnt;

    always #5 wr_clk = ~wr_clk;

    axi_st_patgen_seq #(.TIMEOUT_W(TW)) dut (
        .wr_clk      (wr_clk),
        .rst         (rst),
        .start       (start),
        .cfg_pat_mask(cfg_pat_mask),
        .cfg_beats   (cfg_beats),
        .cfg_timeout (cfg_timeout),
        .patgen_en   (patgen_en),
        .patgen_sel  (patgen_sel),
        .patgen_cnt  (patgen_cnt),
        .axist_valid (axist_valid),
        .axist_rdy   (axist_rdy),
        .chk_done    (chk_done),
        .chk_pass    (chk_pass),
        .busy        (busy),
        .done        (done),
        .pass_vec    (pass_vec),
        .timeout_err (timeout_err),
        .beat_cnt    (beat_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Per-pattern stimulus: handshake bitmaps relative to LOAD, checker timing and verdict
    bit hv[3][128];
    bit hr[3][128];
    int cdel[3];
    bit cpass[3];

    // Model results per pattern
    bit en_p[3];
    int lt[3];
    int et[3];
    int bcnt[3];
    bit res[3];
    bit tmo[3];
    int done_t;

    task automatic prep(input int mode, input int cd, input logic [2:0] pb);
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 128; k++) begin
                case (mode)
                    1: begin hv[p][k] = 1'b1; hr[p][k] = 1'b1; end
                    2: begin hv[p][k] = 1'b1; hr[p][k] = 1'b0; end
                    default: begin
                        hv[p][k] = ($urandom_range(3) != 0);
                        hr[p][k] = ($urandom_range(1) != 0);
                    end
                endcase
            end
            cdel[p]  = cd;
            cpass[p] = pb[p];
        end
    endtask

    // Timeline model: LOAD at relative cycle 0, watchdog expiry at relative cycle t,
    // beats finish at the b-th handshake, verdict taken at the first chk_done in CHECK.
    task automatic model_seq(input logic [2:0] mask, input int b, input int t);
        int cur, end_run, cum, eff, last_run;
        cur = 1;
        for (int p = 0; p < 3; p++) begin
            en_p[p] = mask[p];
            tmo[p]  = 1'b0;
            res[p]  = 1'b0;
            lt[p]   = -10;
            et[p]   = 0;
            bcnt[p] = 0;
            if (mask[p]) begin
                end_run = 1000;
                if (b == 0) begin
                    end_run = 1;
                end else begin
                    cum = 0;
                    for (int k = 1; k < 100; k++) begin
                        if (hv[p][k] && hr[p][k]) cum++;
                        if (cum == b && end_run == 1000) end_run = k;
                    end
                end
                if (t != 0 && t <= end_run) begin
                    tmo[p] = 1'b1;
                    et[p]  = t;
                end else begin
                    eff = (cdel[p] > end_run + 1) ? cdel[p] : end_run + 1;
                    if (t != 0 && t < eff) begin
                        tmo[p] = 1'b1;
                        et[p]  = t;
                    end else begin
                        res[p] = cpass[p];
                        et[p]  = eff;
                    end
                end
                last_run = (et[p] < end_run) ? et[p] : end_run;
                cum = 0;
                for (int k = 1; k <= last_run && k < 128; k++) begin
                    if (hv[p][k] && hr[p][k]) cum++;
                end
                bcnt[p] = cum;
                lt[p]   = cur;
                cur     = cur + et[p] + 1;
            end
        end
        done_t = cur;
    endtask

    // Runs one sequence; entered and left at the sample point just after a rising edge
    task automatic run_seq(input logic [2:0] mask, input int b, input int t,
                           output logic [2:0] got_pv, output logic got_te, output int got_done);
        int act, rel;
        logic exp_en, exp_busy, exp_done, exp_te;
        logic [2:0] exp_pv;
        model_seq(mask, b, t);
        exp_pv = 3'b000;
        exp_te = 1'b0;
        for (int p = 0; p < 3; p++) begin
            if (en_p[p]) begin
                if (tmo[p]) exp_te = 1'b1;
                else exp_pv[p] = res[p];
            end
        end
        got_pv = 3'b000;
        got_te = 1'b0;
        got_done = -1;
        for (int n = 0; n <= done_t + 1; n++) begin
            if (n > 0) begin
                @(posedge wr_clk);
                #1;
            end
            exp_en = 1'b0;
            act = -1;
            for (int p = 0; p < 3; p++) begin
                if (en_p[p] && n == lt[p]) exp_en = 1'b1;
                if (en_p[p] && n >= lt[p] && n <= lt[p] + et[p]) act = p;
            end
            exp_busy = (n >= 1) && (n <= done_t);
            exp_done = (n == done_t);
            check("ctrl_busy_en_done", int'({busy, patgen_en, done}), int'({exp_busy, exp_en, exp_done}));
            if (done && got_done < 0) got_done = n;
            for (int p = 0; p < 3; p++) begin
                if (en_p[p] && n == lt[p]) begin
                    check("patgen_sel", int'(patgen_sel), p);
                    check("patgen_cnt", int'(patgen_cnt), b);
                end
                if (en_p[p] && n == lt[p] + et[p] + 1) begin
                    check("beat_cnt", int'(beat_cnt), bcnt[p]);
                end
            end
            if (n == done_t) begin
                got_pv = pass_vec;
                got_te = timeout_err;
                check("model_pass_vec", int'(pass_vec), int'(exp_pv));
                check("model_timeout_err", int'(timeout_err), int'(exp_te));
            end
            // drive inputs for the coming cycle
            if (n == 0) begin
                start        = 1'b1;
                cfg_pat_mask = mask;
                cfg_beats    = 9'(b);
                cfg_timeout  = TW'(t);
            end else begin
                start        = (n < done_t) && ($urandom_range(3) == 0);
                cfg_pat_mask = 3'($urandom);
                cfg_beats    = 9'($urandom);
                cfg_timeout  = TW'($urandom_range(1, 4));
            end
            if (act >= 0) begin
                rel         = n - lt[act];
                axist_valid = hv[act][rel];
                axist_rdy   = hr[act][rel];
                chk_done    = (rel >= cdel[act]);
                chk_pass    = cpass[act];
            end else begin
                axist_valid = ($urandom_range(1) != 0);
                axist_rdy   = ($urandom_range(1) != 0);
                chk_done    = ($urandom_range(1) != 0);
                chk_pass    = ($urandom_range(1) != 0);
            end
        end
        $display("seq mask=%b beats=%0d timeout=%0d pass_vec=%b timeout_err=%0d done_at=%0d",
                 mask, b, t, got_pv, got_te, got_done);
    endtask

    typedef struct {
        logic [2:0] mask;
        int         beats;
        int         tmo;
        int         hs_mode;
        int         cdel;
        logic [2:0] pbits;
        logic [2:0] exp_pv;
        logic       exp_te;
        int         exp_done;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [2:0] gpv;
        logic       gte;
        int         gdone;
        logic [2:0] rmask;
        int         rb, rt, cnt;

        // mask, beats, timeout, handshake mode, chk delay, verdicts, pass_vec, timeout_err, done cycle
        tbl[0] = '{3'b111, 4, 0,  1, 5,   3'b111, 3'b111, 1'b0, 19};
        tbl[1] = '{3'b101, 3, 0,  1, 4,   3'b001, 3'b001, 1'b0, 11};
        tbl[2] = '{3'b010, 8, 20, 2, 100, 3'b111, 3'b000, 1'b1, 22};
        tbl[3] = '{3'b001, 2, 5,  1, 5,   3'b111, 3'b001, 1'b0, 7};
        tbl[4] = '{3'b000, 4, 0,  1, 1,   3'b111, 3'b000, 1'b0, 1};
        tbl[5] = '{3'b100, 0, 0,  1, 2,   3'b100, 3'b100, 1'b0, 4};
        tbl[6] = '{3'b011, 1, 6,  1, 100, 3'b111, 3'b000, 1'b1, 15};
        tbl[7] = '{3'b001, 3, 0,  1, 1,   3'b001, 3'b001, 1'b0, 6};

        // reset state
        repeat (2) @(posedge wr_clk);
        #1;
        check("reset_outputs", int'({patgen_en, patgen_sel, patgen_cnt, busy, done, pass_vec, timeout_err, beat_cnt}), 0);
        #3 rst = 1'b0;
        @(posedge wr_clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            prep(tbl[i].hs_mode, tbl[i].cdel, tbl[i].pbits);
            run_seq(tbl[i].mask, tbl[i].beats, tbl[i].tmo, gpv, gte, gdone);
            check("tbl_pass_vec", int'(gpv), int'(tbl[i].exp_pv));
            check("tbl_timeout_err", int'(gte), int'(tbl[i].exp_te));
            check("tbl_done_cycle", gdone, tbl[i].exp_done);
        end

        // reset asserted mid-RUN with three beats accepted
        start        = 1'b1;
        cfg_pat_mask = 3'b111;
        cfg_beats    = 9'd8;
        cfg_timeout  = '0;
        axist_valid  = 1'b1;
        axist_rdy    = 1'b1;
        chk_done     = 1'b0;
        @(posedge wr_clk);
        #1;
        start = 1'b0;
        check("rst_seq_load", int'(patgen_en), 1);
        repeat (4) begin
            @(posedge wr_clk);
            #1;
        end
        check("rst_seq_beats_before", int'(beat_cnt), 3);
        check("rst_seq_busy_before", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_outputs", int'({patgen_en, patgen_sel, patgen_cnt, busy, done, pass_vec, timeout_err, beat_cnt}), 0);
        @(posedge wr_clk);
        #1;
        check("rst_held_outputs", int'({patgen_en, patgen_sel, patgen_cnt, busy, done, pass_vec, timeout_err, beat_cnt}), 0);
        #2 rst = 1'b0;
        axist_valid = 1'b0;
        axist_rdy   = 1'b0;
        prep(tbl[0].hs_mode, tbl[0].cdel, tbl[0].pbits);
        run_seq(tbl[0].mask, tbl[0].beats, tbl[0].tmo, gpv, gte, gdone);
        check("post_rst_pass_vec", int'(gpv), 7);
        check("post_rst_done_cycle", gdone, 19);

        // randomized sequences against the timeline model
        for (int it = 0; it < 40; it++) begin
            rmask = 3'($urandom);
            rb    = $urandom_range(0, 8);
            rt    = ($urandom_range(3) == 0) ? 0 : $urandom_range(3, 40);
            prep(0, 1, 3'($urandom));
            for (int p = 0; p < 3; p++) cdel[p] = $urandom_range(1, rb + 8);
            if (rt == 0) begin
                for (int p = 0; p < 3; p++) begin
                    cnt = 0;
                    for (int k = 1; k < 100; k++) if (hv[p][k] && hr[p][k]) cnt++;
                    if (rmask[p] && cnt < rb) rt = 60;
                end
            end
            run_seq(rmask, rb, rt, gpv, gte, gdone);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
